// File: rtl/icache_line_fill_pkg.sv
// Shared types and constants for the icache line-fill sequencer.
// Holds the state encoding, derived size helpers and the line-base mask.
package icache_line_fill_pkg;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FLUSH = 2'd1;
  localparam logic [1:0] S_FETCH = 2'd2;
  localparam logic [1:0] S_WRITE = 2'd3;

  localparam int L2LINE_DEF  = 7;
  localparam int L2DEPTH_DEF = 6;

  function automatic int log2words(int l2line);
    return l2line - 5;
  endfunction

  function automatic int words(int l2line);
    return 1 << (l2line - 5);
  endfunction

  function automatic int tagsize(int l2line, int l2depth);
    return 32 - (l2line - 3) - l2depth;
  endfunction

  function automatic logic [31:0] line_base(
    logic [31:0] a,
    int          l2line
  );
    logic [31:0] m;
    m = (32'd1 << (l2line - 3)) - 32'd1;
    return a & ~m;
  endfunction

endpackage

// File: rtl/icache_line_fill_if.sv
// Word-read bus between the line-fill sequencer and memory.
// master: issues req/addr; slave: returns ready and in-order valid/data.
interface icache_line_fill_if;

  logic        rd_req;
  logic [31:0] rd_addr;
  logic        rd_ready;
  logic        rd_valid;
  logic [31:0] rd_data;

  modport master (
    output rd_req,
    output rd_addr,
    input  rd_ready,
    input  rd_valid,
    input  rd_data
  );

  modport slave (
    input  rd_req,
    input  rd_addr,
    output rd_ready,
    output rd_valid,
    output rd_data
  );

endinterface

// File: rtl/icache_fill_issue.sv
// Issue/receive counters with outstanding limit and wrap-order word index.
// start loads start_idx and clears counters; req_idx/rsp_idx are wrapped.
module icache_fill_issue
  import icache_line_fill_pkg::*;
#(
  parameter int LOG2WORDS       = 2,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                 mem_clk,
  input  logic                 resetn,
  input  logic                 start,
  input  logic [LOG2WORDS-1:0] start_idx,
  input  logic                 req_fire,
  input  logic                 rsp_fire,
  output logic                 req_ok,
  output logic [LOG2WORDS-1:0] req_idx,
  output logic [LOG2WORDS-1:0] rsp_idx,
  output logic                 rsp_last,
  output logic                 rsp_full
);

  localparam int CW = LOG2WORDS + 1;
  localparam logic [CW-1:0] WORDS_C = CW'(1 << LOG2WORDS);
  localparam logic [CW-1:0] MAXO_C  = CW'(MAX_OUTSTANDING);
  localparam logic [CW-1:0] ONE_C   = CW'(1);

  logic [CW-1:0]        issued_q, issued_d;
  logic [CW-1:0]        recvd_q, recvd_d;
  logic [LOG2WORDS-1:0] start_q, start_d;
  logic [CW-1:0]        inflight;

  always_comb begin
    issued_d = issued_q;
    recvd_d  = recvd_q;
    start_d  = start_q;
    if (start) begin
      issued_d = '0;
      recvd_d  = '0;
      start_d  = start_idx;
    end else begin
      if (req_fire) issued_d = issued_q + ONE_C;
      if (rsp_fire) recvd_d  = recvd_q + ONE_C;
    end
  end

  always_ff @(posedge mem_clk or negedge resetn) begin
    if (!resetn) begin
      issued_q <= '0;
      recvd_q  <= '0;
      start_q  <= '0;
    end else begin
      issued_q <= issued_d;
      recvd_q  <= recvd_d;
      start_q  <= start_d;
    end
  end

  assign inflight = issued_q - recvd_q;
  assign req_ok   = (issued_q < WORDS_C) && (inflight < MAXO_C);
  // index arithmetic wraps naturally modulo WORDS
  assign req_idx  = start_q + issued_q[LOG2WORDS-1:0];
  assign rsp_idx  = start_q + recvd_q[LOG2WORDS-1:0];
  assign rsp_last = (recvd_q == WORDS_C - ONE_C);
  assign rsp_full = (recvd_q == WORDS_C);

endmodule

// File: rtl/icache_line_fill.sv
// Icache refill/flush sequencer: fetches a line as word reads, writes it to
// the fill port, and sweeps all indices on flush. Ports: miss_req/addr/ack,
// flush_req, busy, mem (icache_line_fill_if.master), fill_addr/data/we,
// fill_flush/fill_flush_idx, fill_done. Macro: ICACHE_CRITICAL_WORD_FIRST_EN
// selects missing-word-first fetch order (default: ascending from word 0).
module icache_line_fill
  import icache_line_fill_pkg::*;
#(
  parameter int LOG2CACHELINESIZE = L2LINE_DEF,
  parameter int LOG2CACHEDEPTH    = L2DEPTH_DEF,
  parameter int MAX_OUTSTANDING   = 4
) (
  input  logic                              mem_clk,
  input  logic                              resetn,
  input  logic                              miss_req,
  input  logic [31:0]                       miss_addr,
  output logic                              miss_ack,
  input  logic                              flush_req,
  output logic                              busy,
  icache_line_fill_if.master                mem,
  output logic [31:0]                       fill_addr,
  output logic [(1<<LOG2CACHELINESIZE)-1:0] fill_data,
  output logic                              fill_we,
  output logic                              fill_flush,
  output logic [LOG2CACHEDEPTH-1:0]         fill_flush_idx,
  output logic                              fill_done
);

  localparam int LW = log2words(LOG2CACHELINESIZE);
  localparam int LB = 1 << LOG2CACHELINESIZE;
  localparam logic [LOG2CACHEDEPTH-1:0] FIDX_LAST = '1;
  localparam logic [LOG2CACHEDEPTH-1:0] FIDX_ONE  =
    LOG2CACHEDEPTH'(1);

  logic [1:0]                state_q, state_d;
  logic [31:0]               base_q, base_d;
  logic                      ack_q, ack_d;
  logic                      pend_q, pend_d;
  logic [LOG2CACHEDEPTH-1:0] fidx_q, fidx_d;
  logic [LB-1:0]             data_q, data_d;

  logic          accept;
  logic [LW-1:0] start_idx;
  logic          req_ok;
  logic [LW-1:0] req_idx;
  logic [LW-1:0] rsp_idx;
  logic          rsp_last;
  logic          rsp_full;
  logic          req_fire;
  logic          rsp_fire;

`ifdef ICACHE_CRITICAL_WORD_FIRST_EN
  assign start_idx = miss_addr[LOG2CACHELINESIZE-4:2];
`else
  assign start_idx = '0;
`endif

  icache_fill_issue #(
    .LOG2WORDS       (LW),
    .MAX_OUTSTANDING (MAX_OUTSTANDING)
  ) u_issue (
    .mem_clk   (mem_clk),
    .resetn    (resetn),
    .start     (accept),
    .start_idx (start_idx),
    .req_fire  (req_fire),
    .rsp_fire  (rsp_fire),
    .req_ok    (req_ok),
    .req_idx   (req_idx),
    .rsp_idx   (rsp_idx),
    .rsp_last  (rsp_last),
    .rsp_full  (rsp_full)
  );

  assign mem.rd_req  = (state_q == S_FETCH) && req_ok;
  assign mem.rd_addr = {base_q[31:LOG2CACHELINESIZE-3], req_idx, 2'b00};
  assign req_fire    = mem.rd_req && mem.rd_ready;
  // stray or surplus responses are dropped
  assign rsp_fire    = (state_q == S_FETCH) && mem.rd_valid && !rsp_full;

  always_comb begin
    state_d = state_q;
    base_d  = base_q;
    ack_d   = 1'b0;
    pend_d  = pend_q;
    fidx_d  = fidx_q;
    data_d  = data_q;
    accept  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (flush_req || pend_q) begin
          state_d = S_FLUSH;
          pend_d  = 1'b0;
        end else if (miss_req) begin
          accept = 1'b1;
        end
      end
      S_FLUSH: begin
        fidx_d = fidx_q + FIDX_ONE;
        if (fidx_q == FIDX_LAST) begin
          fidx_d  = '0;
          state_d = S_IDLE;
          // a miss held through the sweep is taken on the way out
          if (miss_req) accept = 1'b1;
        end
      end
      S_FETCH: begin
        if (flush_req) pend_d = 1'b1;
        if (rsp_fire) begin
          data_d[32*int'(rsp_idx) +: 32] = mem.rd_data;
          if (rsp_last) state_d = S_WRITE;
        end
      end
      default: begin
        if (flush_req || pend_q) begin
          state_d = S_FLUSH;
          pend_d  = 1'b0;
        end else begin
          state_d = S_IDLE;
        end
      end
    endcase
    if (accept) begin
      state_d = S_FETCH;
      base_d  = line_base(miss_addr, LOG2CACHELINESIZE);
      ack_d   = 1'b1;
    end
  end

  always_ff @(posedge mem_clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= S_IDLE;
      base_q  <= '0;
      ack_q   <= 1'b0;
      pend_q  <= 1'b0;
      fidx_q  <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
      ack_q   <= ack_d;
      pend_q  <= pend_d;
      fidx_q  <= fidx_d;
      data_q  <= data_d;
    end
  end

  assign miss_ack       = ack_q;
  assign busy           = (state_q != S_IDLE) || pend_q || flush_req;
  assign fill_addr      = base_q;
  assign fill_data      = data_q;
  assign fill_we        = (state_q == S_WRITE);
  assign fill_done      = (state_q == S_WRITE);
  assign fill_flush     = (state_q == S_FLUSH);
  assign fill_flush_idx = fidx_q;

endmodule

// File: tb/tb_icache_line_fill.sv
// Randomized self-checking bench for icache_line_fill.
// Memory responder plus a line-level reference model of expected fills.
module tb_icache_line_fill;

  localparam int MAXO  = 4;
  localparam int DEPTH = 64;

  logic         mem_clk = 1'b0;
  logic         resetn  = 1'b1;
  logic         miss_req = 1'b0;
  logic [31:0]  miss_addr = '0;
  logic         flush_req = 1'b0;
  logic         miss_ack, busy, fill_we, fill_flush, fill_done;
  logic [31:0]  fill_addr;
  logic [127:0] fill_data;
  logic [5:0]   fill_flush_idx;

  always #5 mem_clk = ~mem_clk;

  icache_line_fill_if mem ();

  icache_line_fill #(
    .LOG2CACHELINESIZE (7),
    .LOG2CACHEDEPTH    (6),
    .MAX_OUTSTANDING   (MAXO)
  ) u_dut (
    .mem_clk        (mem_clk),
    .resetn         (resetn),
    .miss_req       (miss_req),
    .miss_addr      (miss_addr),
    .miss_ack       (miss_ack),
    .flush_req      (flush_req),
    .busy           (busy),
    .mem            (mem),
    .fill_addr      (fill_addr),
    .fill_data      (fill_data),
    .fill_we        (fill_we),
    .fill_flush     (fill_flush),
    .fill_flush_idx (fill_flush_idx),
    .fill_done      (fill_done)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(string tag, logic [127:0] got, logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  int cyc = 0;
  initial forever begin
    @(posedge mem_clk);
    cyc++;
  end

  int           mode = 0;
  logic [31:0]  pa_q[$];
  int           due_q[$];
  logic [31:0]  acc_q[$];
  int           acc_cyc_q[$];
  int           fl_idx_q[$];
  int           ack_cnt = 0, ack_cyc = 0, we_cnt = 0, we_cyc = 0;
  int           rsp_cnt = 0, outst = 0, max_out = 0, done_bad = 0;
  int           fl_runs = 0, fl_first = 0, fl_last = 0, ack_in_flush = 0;
  logic         prev_fl = 1'b0;
  logic [127:0] we_data = '0;
  logic [31:0]  we_addr = '0;

  // memory model and output monitor, evaluated mid-cycle
  initial begin
    int d;
    mem.rd_ready = 1'b0;
    mem.rd_valid = 1'b0;
    mem.rd_data  = '0;
    forever begin
      @(negedge mem_clk);
      if (!resetn) begin
        pa_q.delete();
        due_q.delete();
        mem.rd_valid = 1'b0;
        mem.rd_ready = 1'b0;
        outst   = 0;
        prev_fl = 1'b0;
        continue;
      end
      case (mode)
        0:       mem.rd_ready = 1'b1;
        1:       mem.rd_ready = 1'($urandom_range(0, 1));
        default: mem.rd_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
      endcase
      if (pa_q.size() > 0 && due_q[0] <= cyc) begin
        mem.rd_valid = 1'b1;
        mem.rd_data  = mem_word(pa_q[0]);
        void'(pa_q.pop_front());
        void'(due_q.pop_front());
        rsp_cnt++;
        outst--;
      end else begin
        mem.rd_valid = 1'b0;
        mem.rd_data  = $urandom;
      end
      if (mem.rd_req && mem.rd_ready) begin
        d = (mode == 0) ? 0 : (mode == 1) ? $urandom_range(0, 3) : 2;
        acc_q.push_back(mem.rd_addr);
        acc_cyc_q.push_back(cyc);
        pa_q.push_back(mem.rd_addr);
        due_q.push_back(cyc + 1 + d);
        outst++;
        if (outst > max_out) max_out = outst;
      end
      if (miss_ack) begin
        ack_cnt++;
        ack_cyc = cyc;
        if (fill_flush) ack_in_flush++;
      end
      if (fill_we) begin
        we_cnt++;
        we_cyc  = cyc;
        we_data = fill_data;
        we_addr = fill_addr;
      end
      if (fill_done !== fill_we) done_bad++;
      if (fill_flush) begin
        fl_idx_q.push_back(int'(fill_flush_idx));
        if (!prev_fl) begin
          fl_runs++;
          fl_first = cyc;
        end
        fl_last = cyc;
      end
      prev_fl = fill_flush;
    end
  end

  // one complete miss; optional flush pulse with the miss or fl_at cycles in
  task automatic do_miss(input logic [31:0] a, input bit fl_pre,
                         input int fl_at);
    logic [31:0]  base;
    logic [127:0] line;
    int           st, a0, w0;
    bit           ok;
    base = a & 32'hFFFF_FFF0;
`ifdef ICACHE_CRITICAL_WORD_FIRST_EN
    st = int'(a[3:2]);
`else
    st = 0;
`endif
    for (int k = 0; k < 4; k++)
      line[32*k +: 32] = mem_word(base + 32'(4 * k));
    acc_q.delete();
    acc_cyc_q.delete();
    a0 = ack_cnt;
    w0 = we_cnt;
    miss_req  = 1'b1;
    miss_addr = a;
    flush_req = fl_pre;
    ok = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      @(posedge mem_clk);
      #2;
      flush_req = 1'b0;
      if (ack_cnt != a0) begin
        ok = 1'b1;
        break;
      end
    end
    miss_req  = 1'b0;
    miss_addr = $urandom;
    chk("ack_timeout", 128'(ok), 128'd1);
    chk("busy_fetch", 128'(busy), 128'd1);
    ok = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      if (we_cnt != w0) begin
        ok = 1'b1;
        break;
      end
      @(posedge mem_clk);
      #2;
      flush_req = (fl_at > 0) && (i == fl_at);
    end
    flush_req = 1'b0;
    chk("we_timeout", 128'(ok), 128'd1);
    chk("fill_addr", 128'(we_addr), 128'(base));
    chk("fill_data", we_data, line);
    chk("n_reads", 128'(acc_q.size()), 128'd4);
    for (int k = 0; k < acc_q.size() && k < 4; k++)
      chk("rd_addr", 128'(acc_q[k]),
          128'(base + 32'(4 * ((st + k) % 4))));
  endtask

  task automatic chk_zero(string tag);
    chk({tag, "_ack"}, 128'(miss_ack), 128'd0);
    chk({tag, "_req"}, 128'(mem.rd_req), 128'd0);
    chk({tag, "_raddr"}, 128'(mem.rd_addr), 128'd0);
    chk({tag, "_we"}, 128'(fill_we), 128'd0);
    chk({tag, "_done"}, 128'(fill_done), 128'd0);
    chk({tag, "_flush"}, 128'(fill_flush), 128'd0);
    chk({tag, "_fidx"}, 128'(fill_flush_idx), 128'd0);
    chk({tag, "_busy"}, 128'(busy), 128'd0);
    chk({tag, "_faddr"}, 128'(fill_addr), 128'd0);
    chk({tag, "_fdata"}, fill_data, 128'd0);
  endtask

  task automatic chk_sweep(string tag, int f0);
    int bad;
    bad = 0;
    chk({tag, "_runs"}, 128'(fl_runs - f0), 128'd1);
    chk({tag, "_len"}, 128'(fl_idx_q.size()), 128'(DEPTH));
    for (int i = 0; i < fl_idx_q.size(); i++)
      if (fl_idx_q[i] != i) bad++;
    chk({tag, "_order"}, 128'(bad), 128'd0);
    chk({tag, "_contig"}, 128'(fl_last - fl_first), 128'(DEPTH - 1));
  endtask

  initial begin
    int w1, f0, a0, w0, r0;
    #2 resetn = 1'b0;
    #1 chk_zero("rst");
    repeat (3) @(posedge mem_clk);
    #2 resetn = 1'b1;

    // zero-wait miss, latency and back-to-back acceptance
    mode = 0;
    do_miss(32'h0000_1238, 1'b0, 0);
    chk("lat_we", 128'(we_cyc - ack_cyc), 128'd5);
    if (acc_cyc_q.size() == 4) begin
      chk("lat_req0", 128'(acc_cyc_q[0] - ack_cyc), 128'd0);
      chk("lat_req3", 128'(acc_cyc_q[3] - ack_cyc), 128'd3);
    end
    w1 = we_cyc;
    do_miss(32'h0000_ABC4, 1'b0, 0);
    chk("b2b_ack", 128'(ack_cyc - w1), 128'd2);

    // backpressure pattern 1,0,0,1 with slow responses
    mode = 2;
    do_miss(32'h0040_00FC, 1'b0, 0);

    // random ready and response latency
    mode = 1;
    repeat (12) do_miss($urandom, 1'b0, 0);
    chk("max_inflight", 128'(max_out <= MAXO), 128'd1);

    // flush during fetch, plus a redundant request mid-sweep
    mode = 0;
    f0 = fl_runs;
    fl_idx_q.delete();
    do_miss(32'h0000_2004, 1'b0, 1);
    repeat (10) @(posedge mem_clk);
    #2 flush_req = 1'b1;
    @(posedge mem_clk);
    #2 flush_req = 1'b0;
    repeat (120) @(posedge mem_clk);
    #2;
    chk_sweep("fetch_flush", f0);
    chk("flush_after_we", 128'(fl_first > we_cyc), 128'd1);

    // flush and miss together in idle
    f0 = fl_runs;
    fl_idx_q.delete();
    do_miss(32'h0000_3338, 1'b1, 0);
    chk_sweep("sim_flush", f0);
    chk("sim_ack_gap", 128'(ack_cyc - fl_last), 128'd1);
    chk("ack_in_flush", 128'(ack_in_flush), 128'd0);

    // reset after two responses
    a0 = ack_cnt;
    w0 = we_cnt;
    r0 = rsp_cnt;
    miss_req  = 1'b1;
    miss_addr = 32'h0000_5550;
    for (int i = 0; i < 200; i++) begin
      @(posedge mem_clk);
      #2;
      if (ack_cnt != a0) miss_req = 1'b0;
      if (rsp_cnt - r0 >= 2) break;
    end
    miss_req = 1'b0;
    chk("rst_two_rsp", 128'(rsp_cnt - r0), 128'd2);
    resetn = 1'b0;
    #1 chk_zero("midrst");
    repeat (3) @(posedge mem_clk);
    #2 resetn = 1'b1;
    repeat (20) @(posedge mem_clk);
    #2 chk("rst_no_we", 128'(we_cnt - w0), 128'd0);
    do_miss(32'h0000_7778, 1'b0, 0);

    repeat (5) @(posedge mem_clk);
    #2;
    chk("done_eq_we", 128'(done_bad), 128'd0);
    chk("idle_busy", 128'(busy), 128'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/icache_line_fill.md
# icache_line_fill

Refill and flush sequencer for the instruction cache, running entirely on mem_clk. On a cache miss it fetches one full cache line from the memory hierarchy as pipelined 32-bit word reads and assembles the words. It then writes the line into the cache's fill port (fill address, line data, write enable). It also generates the index sweep that invalidates every cache line on a flush request.

## Interface
- LOG2CACHELINESIZE, 7, line size in bits (log2); 128-bit line = 4 words
- LOG2CACHEDEPTH, 6, number of lines (log2)
- MAX_OUTSTANDING, 4, word reads in flight; 1..2^(LOG2CACHELINESIZE-5)

Ports:
- mem_clk  in  1  clock
- resetn  in  1  reset; asynchronous, active-low
- miss_req  in  1  level; held high until miss_ack
- miss_addr  in  32  byte address of the missing instruction; stable while miss_req high
- miss_ack  out  1  one-cycle pulse when the miss is accepted
- flush_req  in  1  one-cycle pulse requesting a full invalidate
- busy  out  1  high in any state other than S_IDLE, or while a flush is pending
- mem_rd_req  out  1  word read request
- mem_rd_addr  out  32  word-aligned byte address
- mem_rd_ready  in  1  request accepted when req && ready
- mem_rd_valid  in  1  in-order read response
- mem_rd_data  in  32  response data
- fill_addr  out  32  line-aligned byte address; low LOG2CACHELINESIZE-3 bits are 0
- fill_data  out  2^LOG2CACHELINESIZE  assembled line
- fill_we  out  1  one-cycle line write strobe
- fill_flush  out  1  invalidate strobe
- fill_flush_idx  out  LOG2CACHEDEPTH  line index being invalidated
- fill_done  out  1  one-cycle pulse, coincident with fill_we

## Operation
- States: S_IDLE, S_FLUSH, S_FETCH, S_WRITE.
- **S_IDLE**
  - A flush is pending (flush_req this cycle or latched earlier): go to S_FLUSH. A flush wins over a simultaneous miss_req.
  - Otherwise, if miss_req is high: capture line base = miss_addr with the low 4 bits cleared, pulse miss_ack, and go to S_FETCH.
- **S_FETCH**
  - Issue word reads in wrap order from the start index.
  - issued count increments on req && ready. mem_rd_req is high while issued < WORDS and issued − received < MAX_OUTSTANDING.
  - Word index = (start + n) mod WORDS. mem_rd_addr = {base[31:4], idx, 2'b00}.
  - Each mem_rd_valid writes mem_rd_data into fill_data[32·idx+31 : 32·idx], so word k always lands at bits 32k+31:32k regardless of fetch order. The received count increments.
  - When received == WORDS, go to S_WRITE.
- **S_WRITE**: assert fill_we and fill_done for one cycle with fill_addr = base, then go to S_IDLE.
- **S_FLUSH**
  - Index counter runs from 0 to CACHEDEPTH−1, one index per cycle, with fill_flush high.
  - After the last index, return to S_IDLE.
- **flush_req while in S_FETCH or S_WRITE**: latched as pending and serviced immediately after S_WRITE. Repeated flush_req pulses while a flush is pending or running collapse into one flush.
- **miss_req during S_FLUSH**: not acknowledged. The requester keeps it high and it is serviced on return to S_IDLE.
- **mem_rd_valid outside S_FETCH**: ignored. mem_rd_valid when received == WORDS is a protocol error and is ignored.
- fill_data holds its last value after S_WRITE.

## Timing
- **Reset values**: state S_IDLE; miss_ack, mem_rd_req, fill_we, fill_flush, fill_done, busy = 0; mem_rd_addr, fill_addr, fill_data, fill_flush_idx = 0; pending flush cleared.
- **Reset mid-fetch**: the partial line is discarded and no fill_we is issued. The memory side is reset by the same resetn.
- **miss_ack**: registered; high in the first S_FETCH cycle. mem_rd_req is also high in that cycle.
- **Zero-wait memory** (ready = 1, valid one cycle after accept), with miss_req sampled at edge 0:
  - Requests at cycles 1–4, responses at 2–5.
  - fill_we at cycle 6.
  - S_IDLE at cycle 7; a new miss can be accepted at the edge ending cycle 7.
- **Flush**: fill_flush is high for exactly CACHEDEPTH consecutive cycles, with fill_flush_idx = 0..CACHEDEPTH−1 in order. It wraps to 0 on exit.

## Configuration
- **ICACHE_CRITICAL_WORD_FIRST_EN defined**: start index = miss_addr[LOG2CACHELINESIZE−4 : 2], so the missing word is fetched first and later indices wrap modulo WORDS.
- **Not defined**: start index = 0, giving a strictly ascending fetch. Data placement in fill_data is identical in both cases.

## Structure
- The shared package holds:
  - state encoding (2-bit localparams S_IDLE=0, S_FLUSH=1, S_FETCH=2, S_WRITE=3)
  - derived constants WORDS = 2^(LOG2CACHELINESIZE−5), LOG2WORDS, TAGSIZE
  - the line-base mask function
- Sub-module `icache_fill_issue`: issued/received counters, outstanding limit, and wrap-order index generation. Shared between the request address path and the response placement path via the start index.

## Test plan
- **Zero-wait miss**: miss at 0x0000_1238 with the macro defined → reads 0x1238, 0x123C, 0x1230, 0x1234. fill_addr = 0x1230, word k in fill_data[32k+31:32k], fill_we at cycle 6.
- **Same miss, macro undefined** → reads ascend 0x1230..0x123C. fill_data is identical.
- **Backpressure**: ready toggling 1,0,0,1 and MAX_OUTSTANDING = 1 → never more than one read in flight. Exactly 4 accepts, a single fill_we, correct data.
- **flush_req during S_FETCH** → the fill completes with fill_we, then 64 consecutive fill_flush cycles with idx 0..63. A second flush_req mid-flush adds no extra sweep.
- **Simultaneous flush_req and miss_req in S_IDLE** → the flush runs first with miss_ack = 0 throughout. miss_ack arrives in the cycle after the last flush index.
- **resetn asserted after 2 responses** → all outputs go to 0 immediately and no fill_we occurs. A later miss completes normally.
